// File: rtl/tim6_ctrl.sv
// TIM6 basic timer: register file, prescaler, auto-reload up-counter and update-event logic.
// Define TIM6_OPM_EN to implement CR1.OPM (one-pulse mode); otherwise bit3 is read-as-zero.
module tim6_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [5:0]       addr,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] rdata,
    output logic             irq,
    output logic             trgo
);

    localparam logic [5:0] A_CR1  = 6'h00;
    localparam logic [5:0] A_DIER = 6'h0C;
    localparam logic [5:0] A_SR   = 6'h10;
    localparam logic [5:0] A_EGR  = 6'h14;
    localparam logic [5:0] A_CNT  = 6'h24;
    localparam logic [5:0] A_PSC  = 6'h28;
    localparam logic [5:0] A_ARR  = 6'h2C;

    logic             cen;
    logic             udis;
    logic             urs;
    logic             opm;
    logic             arpe;
    logic             uie;
    logic             uif;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pc;
    logic [CNT_W-1:0] psc;
    logic [CNT_W-1:0] arr;
    logic [CNT_W-1:0] psc_act;
    logic [CNT_W-1:0] arr_act;
    logic [CNT_W-1:0] rd_mux;

    logic wr_cr1, wr_dier, wr_sr, wr_egr, wr_cnt, wr_psc, wr_arr;
    logic ug, tick, wrap, ovf, uev, uif_set;

    assign wr_cr1  = wr_en && (addr == A_CR1);
    assign wr_dier = wr_en && (addr == A_DIER);
    assign wr_sr   = wr_en && (addr == A_SR);
    assign wr_egr  = wr_en && (addr == A_EGR);
    assign wr_cnt  = wr_en && (addr == A_CNT);
    assign wr_psc  = wr_en && (addr == A_PSC);
    assign wr_arr  = wr_en && (addr == A_ARR);

    assign ug   = wr_egr && wdata[0];
    assign tick = cen && (pc == psc_act);
    assign wrap = tick && (cnt == arr_act);
    // A zero auto-reload pins the counter at 0 without ever signalling overflow;
    // a CNT write in the same cycle supersedes the tick and therefore the overflow.
    assign ovf  = wrap && (arr_act != '0) && !wr_cnt;
    // UG subsumes a coincident overflow, so both collapse into a single UEV.
    assign uev     = (ug || ovf) && !udis;
    assign uif_set = !udis && (ug ? !urs : ovf);

    assign irq = uif && uie;

`ifdef TIM6_OPM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opm <= 1'b0;
        end else if (wr_cr1) begin
            opm <= wdata[3];
        end
    end
`else
    assign opm = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc  <= '0;
            cnt <= '0;
        end else if (ug) begin
            pc  <= '0;
            cnt <= '0;
        end else begin
            if (cen) begin
                pc <= tick ? '0 : pc + CNT_W'(1);
            end
            if (wr_cnt) begin
                cnt <= wdata;
            end else if (tick) begin
                cnt <= (wrap || (arr_act == '0)) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cen     <= 1'b0;
            udis    <= 1'b0;
            urs     <= 1'b0;
            arpe    <= 1'b0;
            uie     <= 1'b0;
            uif     <= 1'b0;
            psc     <= '0;
            arr     <= '0;
            psc_act <= '0;
            arr_act <= '0;
            trgo    <= 1'b0;
        end else begin
            if (wr_cr1) begin
                cen  <= wdata[0];
                udis <= wdata[1];
                urs  <= wdata[2];
                arpe <= wdata[7];
            end
            // One-pulse stop overrides a software CEN write in the same cycle.
            if (uev && opm) begin
                cen <= 1'b0;
            end
            if (wr_dier) begin
                uie <= wdata[0];
            end
            if (uif_set) begin
                uif <= 1'b1;
            end else if (wr_sr && !wdata[0]) begin
                uif <= 1'b0;
            end
            if (wr_psc) begin
                psc <= wdata;
            end
            if (wr_arr) begin
                arr <= wdata;
            end
            if (uev) begin
                psc_act <= psc;
            end
            // Unbuffered ARR writes land directly, taking priority over a shadow reload.
            if (wr_arr && !arpe) begin
                arr_act <= wdata;
            end else if (uev) begin
                arr_act <= arr;
            end
            trgo <= uev;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_CR1: begin
                rd_mux[0] = cen;
                rd_mux[1] = udis;
                rd_mux[2] = urs;
                rd_mux[3] = opm;
                rd_mux[7] = arpe;
            end
            A_DIER:  rd_mux[0] = uie;
            A_SR:    rd_mux[0] = uif;
            A_CNT:   rd_mux = cnt;
            A_PSC:   rd_mux = psc;
            A_ARR:   rd_mux = arr;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_mux;
        end
    end

endmodule
